// File: rtl/capreg_poller.sv
// Wishbone master that periodically scans a 16-bit capture-register bank, clears it with one write,
// and keeps a snapshot plus a sticky irq. Define ACK_TIMEOUT_EN to add the ack timeout and err flag.
module capreg_poller #(
    parameter int ADRBITS = 1,
    parameter int PERIOD  = 1024
`ifdef ACK_TIMEOUT_EN
    ,
    parameter int TOUT    = 15
`endif
) (
    input  logic               wb_clk,
    input  logic               wb_rst,
    input  logic               enable,
    output logic               m_cyc,
    output logic               m_stb,
    output logic               m_we,
    output logic [ADRBITS-1:0] m_adr,
    output logic [15:0]        m_dat_o,
    input  logic [15:0]        m_dat_i,
    input  logic               m_ack,
    input  logic [ADRBITS-1:0] snap_adr,
    output logic [15:0]        snap_dat,
    output logic               irq,
    input  logic               irq_clr,
    output logic               busy,
    output logic               err
);
    localparam int NWORDS = 2 ** ADRBITS;
    localparam int CW     = $clog2(PERIOD);
    localparam logic [CW-1:0]      CNT_MAX  = CW'(PERIOD - 1);
    localparam logic [ADRBITS-1:0] ADR_LAST = ADRBITS'(NWORDS - 1);

    typedef enum logic [2:0] {IDLE, RD, RNEXT, WR, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [ADRBITS-1:0] adr_q, adr_d;
    logic [15:0]        acc_q  [NWORDS];
    logic [15:0]        acc_d  [NWORDS];
    logic [15:0]        snap_q [NWORDS];
    logic [15:0]        snap_d [NWORDS];
    logic [15:0]        snap_dat_q, snap_dat_d;
    logic               irq_q, irq_d;
    logic               start_req;
    logic               any_set;
    logic               abort;

    // Start requests are only honoured in IDLE, so a request during a scan is simply lost.
    always_comb begin
        start_req = enable && (cnt_q == CNT_MAX);
        if (!enable || start_req) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // NOTE: state flops update with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        unique case (state_q)
            IDLE: begin
                if (start_req) begin
                    state_d = RD;
                    adr_d   = '0;
                end
            end
            RD: begin
                if (m_ack) begin
                    state_d = RNEXT;
                end else if (abort) begin
                    state_d = IDLE;
                end
            end
            RNEXT: begin
                // The clear write follows the last read directly to keep the loss window short.
                if (adr_q == ADR_LAST) begin
                    state_d = WR;
                    adr_d   = '0;
                end else begin
                    state_d = RD;
                    adr_d   = adr_q + ADRBITS'(1);
                end
            end
            WR: begin
                if (m_ack) begin
                    state_d = DONE;
                end else if (abort) begin
                    state_d = IDLE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_cyc = (state_q == RD) || (state_q == WR);
        m_stb = m_cyc;
        m_we  = (state_q == WR);
        busy  = (state_q != IDLE);
    end

    always_comb begin
        acc_d = acc_q;
        if (state_q == RD && m_ack) begin
            acc_d[adr_q] = m_dat_i;
        end

        any_set = 1'b0;
        for (int i = 0; i < NWORDS; i++) begin
            any_set = any_set | (acc_q[i] != '0);
        end

        snap_d = snap_q;
        if (state_q == DONE) begin
            snap_d = acc_q;
        end
        snap_dat_d = snap_q[snap_adr];

        // A set in DONE overrides a simultaneous clear.
        irq_d = irq_q;
        if (irq_clr) begin
            irq_d = 1'b0;
        end
        if (state_q == DONE && any_set) begin
            irq_d = 1'b1;
        end
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            cnt_q      <= '0;
            adr_q      <= '0;
            snap_q     <= '{default: '0};
            snap_dat_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            adr_q      <= adr_d;
            snap_q     <= snap_d;
            snap_dat_q <= snap_dat_d;
            irq_q      <= irq_d;
        end
    end

    // NOTE: the accumulator is not reset; a scan rewrites every word before DONE reads it.
    always_ff @(posedge wb_clk) begin
        acc_q <= acc_d;
    end

`ifdef ACK_TIMEOUT_EN
    localparam int TW = $clog2(TOUT + 1);

    logic [TW-1:0] tout_q, tout_d;
    logic          err_q, err_d;
    logic          waiting;

    always_comb begin
        waiting = ((state_q == RD) || (state_q == WR)) && !m_ack;
        tout_d  = waiting ? tout_q + TW'(1) : '0;
        abort   = waiting && (tout_q == TW'(TOUT - 1));
        err_d   = err_q;
        if (irq_clr) begin
            err_d = 1'b0;
        end
        if (abort) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            tout_q <= '0;
            err_q  <= 1'b0;
        end else begin
            tout_q <= tout_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`else
    assign abort = 1'b0;
    assign err   = 1'b0;
`endif

    assign m_adr    = adr_q;
    assign m_dat_o  = '0;
    assign irq      = irq_q;
    assign snap_dat = snap_dat_q;

endmodule

// File: tb/tb_capreg_poller.sv
// Self-checking bench for capreg_poller: a Wishbone slave model checks each bus transaction
// against a scoreboard queue filled when the bank contents for a scan are set up.
`timescale 1ns/1ps
module tb_capreg_poller;
    localparam int ADRBITS = 1;
    localparam int NWORDS  = 2 ** ADRBITS;
    localparam int PERIOD  = 1024;
    localparam int LIMIT   = 2 * PERIOD + 64;
`ifdef ACK_TIMEOUT_EN
    localparam int TOUT    = 15;
`endif

    logic               wb_clk = 1'b0;
    logic               wb_rst = 1'b1;
    logic               enable = 1'b0;
    logic               m_cyc, m_stb, m_we;
    logic [ADRBITS-1:0] m_adr;
    logic [15:0]        m_dat_o;
    logic [15:0]        m_dat_i = '0;
    logic               m_ack = 1'b0;
    logic [ADRBITS-1:0] snap_adr = '0;
    logic [15:0]        snap_dat;
    logic               irq;
    logic               irq_clr = 1'b0;
    logic               busy;
    logic               err;

    always #5 wb_clk = ~wb_clk;

    capreg_poller #(.ADRBITS(ADRBITS), .PERIOD(PERIOD)) dut (
        .wb_clk  (wb_clk),
        .wb_rst  (wb_rst),
        .enable  (enable),
        .m_cyc   (m_cyc),
        .m_stb   (m_stb),
        .m_we    (m_we),
        .m_adr   (m_adr),
        .m_dat_o (m_dat_o),
        .m_dat_i (m_dat_i),
        .m_ack   (m_ack),
        .snap_adr(snap_adr),
        .snap_dat(snap_dat),
        .irq     (irq),
        .irq_clr (irq_clr),
        .busy    (busy),
        .err     (err)
    );

    typedef struct {
        logic               we;
        logic [ADRBITS-1:0] adr;
    } txn_t;

    txn_t        exp_q[$];
    txn_t        sb_exp;
    int          start_q[$];
    int          pass_cnt  = 0;
    int          chk_cnt   = 0;
    int          cyc_n     = 0;
    int          cyc_seen  = 0;
    int          wr_seen   = 0;
    int          stb_cnt   = 0;
    bit          slave_acks = 1'b1;
    logic        busy_prev = 1'b0;
    logic [15:0] bank [NWORDS] = '{default: '0};

    always @(posedge wb_clk) cyc_n <= cyc_n + 1;

    // Slave model: acks in the second cycle of each strobe; the bank clears on any write.
    always @(negedge wb_clk) begin
        if (busy === 1'b1 && busy_prev !== 1'b1) start_q.push_back(cyc_n);
        busy_prev = busy;
        if (m_cyc === 1'b1) cyc_seen++;
        if (m_cyc === 1'b1 && m_stb === 1'b1 && !m_ack) begin
            stb_cnt++;
            if (slave_acks && stb_cnt >= 2) begin
                m_ack = 1'b1;
                chk_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_unexpected: got we=%b adr=%0d, expected no transaction", m_we, m_adr);
                end else begin
                    sb_exp = exp_q.pop_front();
                    if (m_we !== sb_exp.we || m_adr !== sb_exp.adr || (m_we === 1'b1 && m_dat_o !== 16'h0))
                        $display("FAIL sb_txn: got we=%b adr=%0d dat=%h, expected we=%b adr=%0d dat=0000",
                                 m_we, m_adr, m_dat_o, sb_exp.we, sb_exp.adr);
                    else
                        pass_cnt++;
                end
                if (m_we === 1'b1) begin
                    wr_seen++;
                    for (int i = 0; i < NWORDS; i++) bank[i] = '0;
                end else begin
                    m_dat_i = bank[m_adr];
                end
            end
        end else begin
            m_ack   = 1'b0;
            stb_cnt = 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge wb_clk);
    endtask

    task automatic read_snap(input logic [ADRBITS-1:0] a, output logic [15:0] d);
        @(negedge wb_clk);
        snap_adr = a;
        @(negedge wb_clk);
        d = snap_dat;
    endtask

    task automatic push_scan();
        for (int i = 0; i < NWORDS; i++) exp_q.push_back('{we: 1'b0, adr: ADRBITS'(i)});
        exp_q.push_back('{we: 1'b1, adr: '0});
    endtask

    // Waits for a scan to start (unless one is running) and to finish, within a cycle budget.
    task automatic wait_scan(input string name);
        int n;
        n = 0;
        while (busy !== 1'b1 && n < LIMIT) begin @(negedge wb_clk); n++; end
        while (busy !== 1'b0 && n < LIMIT) begin @(negedge wb_clk); n++; end
        chk_cnt++;
        if (n >= LIMIT) $display("FAIL %s_scan_wait: no complete scan within %0d cycles", name, LIMIT);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        int          c0;
        wb_rst = 1'b1;
        tick(3);
        chk_cnt++; if ({m_cyc, m_stb, m_we} !== 3'b000) $display("FAIL rst_bus: cyc/stb/we=%b expected 000", {m_cyc, m_stb, m_we}); else pass_cnt++;
        chk_cnt++; if (m_adr !== '0 || m_dat_o !== 16'h0) $display("FAIL rst_adr_dat: adr=%0d dat=%h expected 0/0000", m_adr, m_dat_o); else pass_cnt++;
        chk_cnt++; if ({busy, irq, err} !== 3'b000) $display("FAIL rst_flags: busy/irq/err=%b expected 000", {busy, irq, err}); else pass_cnt++;
        chk_cnt++; if (snap_dat !== 16'h0) $display("FAIL rst_snap_dat: got %h expected 0000", snap_dat); else pass_cnt++;
        wb_rst = 1'b0;
        c0 = cyc_seen;
        tick(5000);
        chk_cnt++; if (cyc_seen != c0) $display("FAIL idle_no_cyc: m_cyc seen %0d cycles expected 0", cyc_seen - c0); else pass_cnt++;
        chk_cnt++; if (irq !== 1'b0) $display("FAIL idle_irq: got %b expected 0", irq); else pass_cnt++;
        read_snap(0, d);
        chk_cnt++; if (d !== 16'h0) $display("FAIL idle_snap0: got %h expected 0000", d); else pass_cnt++;
        read_snap(1, d);
        chk_cnt++; if (d !== 16'h0) $display("FAIL idle_snap1: got %h expected 0000", d); else pass_cnt++;
    endtask

    task automatic test_basic_scan();
        logic [15:0] d;
        int          w0;
        bank[0] = 16'h0000;
        bank[1] = 16'h8001;
        push_scan();
        start_q.delete();
        w0 = wr_seen;
        enable = 1'b1;
        wait_scan("basic");
        chk_cnt++; if (exp_q.size() != 0) $display("FAIL basic_sb_left: %0d transactions missing expected 0", exp_q.size()); else pass_cnt++;
        chk_cnt++; if (wr_seen != w0 + 1) $display("FAIL basic_writes: got %0d expected 1", wr_seen - w0); else pass_cnt++;
        read_snap(0, d);
        chk_cnt++; if (d !== 16'h0000) $display("FAIL basic_snap0: got %h expected 0000", d); else pass_cnt++;
        read_snap(1, d);
        chk_cnt++; if (d !== 16'h8001) $display("FAIL basic_snap1: got %h expected 8001", d); else pass_cnt++;
        chk_cnt++; if (irq !== 1'b1 || err !== 1'b0) $display("FAIL basic_irq_err: irq/err=%b%b expected 10", irq, err); else pass_cnt++;
        // Bank was cleared by the write, so the next scan reads zeros; irq must stay sticky.
        push_scan();
        wait_scan("period");
        chk_cnt++;
        if (start_q.size() != 2 || start_q[1] - start_q[0] != PERIOD)
            $display("FAIL basic_period: starts=%0d spacing=%0d expected 2 starts %0d apart",
                     start_q.size(), (start_q.size() >= 2) ? start_q[1] - start_q[0] : -1, PERIOD);
        else pass_cnt++;
        read_snap(1, d);
        chk_cnt++; if (d !== 16'h0000) $display("FAIL period_snap1: got %h expected 0000", d); else pass_cnt++;
        chk_cnt++; if (irq !== 1'b1) $display("FAIL irq_sticky: got %b expected 1", irq); else pass_cnt++;
    endtask

    task automatic test_irq_collision();
        logic [15:0] d;
        int          n;
        bank[1] = 16'h0040;
        push_scan();
        n = 0;
        while (m_we !== 1'b1 && n < LIMIT) begin @(negedge wb_clk); n++; end
        tick(2);
        chk_cnt++; if (busy !== 1'b1 || m_cyc !== 1'b0) $display("FAIL coll_done_cycle: busy/cyc=%b%b expected 10", busy, m_cyc); else pass_cnt++;
        irq_clr = 1'b1;
        @(negedge wb_clk);
        irq_clr = 1'b0;
        chk_cnt++; if (irq !== 1'b1) $display("FAIL coll_set_wins: irq=%b expected 1", irq); else pass_cnt++;
        read_snap(1, d);
        chk_cnt++; if (d !== 16'h0040) $display("FAIL coll_snap1: got %h expected 0040", d); else pass_cnt++;
        irq_clr = 1'b1;
        @(negedge wb_clk);
        irq_clr = 1'b0;
        @(negedge wb_clk);
        chk_cnt++; if (irq !== 1'b0) $display("FAIL irq_clear: irq=%b expected 0", irq); else pass_cnt++;
        push_scan();
        wait_scan("zero");
        chk_cnt++; if (irq !== 1'b0 || err !== 1'b0) $display("FAIL zero_scan_flags: irq/err=%b%b expected 00", irq, err); else pass_cnt++;
    endtask

    task automatic test_enable_drop();
        logic [15:0] d;
        int          n, w0, c0;
        bank[0] = 16'h1234;
        bank[1] = 16'h0000;
        push_scan();
        w0 = wr_seen;
        n = 0;
        while (!(m_stb === 1'b1 && m_we === 1'b0 && m_adr === 1'b1) && n < LIMIT) begin @(negedge wb_clk); n++; end
        enable = 1'b0;
        wait_scan("drop");
        chk_cnt++; if (wr_seen != w0 + 1) $display("FAIL drop_write: writes=%0d expected 1", wr_seen - w0); else pass_cnt++;
        chk_cnt++; if (exp_q.size() != 0) $display("FAIL drop_sb_left: %0d transactions missing expected 0", exp_q.size()); else pass_cnt++;
        c0 = cyc_seen;
        tick(3 * PERIOD);
        chk_cnt++; if (cyc_seen != c0) $display("FAIL drop_idle: m_cyc seen %0d cycles expected 0", cyc_seen - c0); else pass_cnt++;
        read_snap(0, d);
        chk_cnt++; if (d !== 16'h1234 || irq !== 1'b1) $display("FAIL drop_result: snap0=%h irq=%b expected 1234/1", d, irq); else pass_cnt++;
    endtask

    task automatic test_reset_mid_scan();
        logic [15:0] d;
        int          n;
        snap_adr = 1'b0;
        bank[0] = 16'h00FF;
        bank[1] = 16'h0001;
        push_scan();
        enable = 1'b1;
        n = 0;
        while (!(m_stb === 1'b1 && m_we === 1'b1) && n < LIMIT) begin @(negedge wb_clk); n++; end
        wb_rst = 1'b1;
        @(negedge wb_clk);
        chk_cnt++; if ({m_cyc, m_stb, busy} !== 3'b000) $display("FAIL rstmid_bus: cyc/stb/busy=%b expected 000", {m_cyc, m_stb, busy}); else pass_cnt++;
        chk_cnt++; if (snap_dat !== 16'h0 || irq !== 1'b0) $display("FAIL rstmid_snap_irq: snap=%h irq=%b expected 0000/0", snap_dat, irq); else pass_cnt++;
        wb_rst = 1'b0;
        enable = 1'b0;
        chk_cnt++; if (exp_q.size() != 1) $display("FAIL rstmid_no_write: %0d pending expected 1", exp_q.size()); else pass_cnt++;
        exp_q.delete();
        for (int i = 0; i < NWORDS; i++) bank[i] = '0;
        read_snap(1, d);
        chk_cnt++; if (d !== 16'h0) $display("FAIL rstmid_snap1: got %h expected 0000", d); else pass_cnt++;
    endtask

`ifdef ACK_TIMEOUT_EN
    task automatic test_timeout();
        logic [15:0] d;
        int          n;
        slave_acks = 1'b0;
        enable = 1'b1;
        n = 0;
        while (busy !== 1'b1 && n < LIMIT) begin @(negedge wb_clk); n++; end
        n = 0;
        while (m_cyc === 1'b1 && n < 100) begin @(negedge wb_clk); n++; end
        chk_cnt++; if (n != TOUT) $display("FAIL tout_len: m_cyc high %0d cycles expected %0d", n, TOUT); else pass_cnt++;
        chk_cnt++; if (err !== 1'b1 || busy !== 1'b0) $display("FAIL tout_err: err/busy=%b%b expected 10", err, busy); else pass_cnt++;
        read_snap(0, d);
        chk_cnt++; if (d !== 16'h0 || irq !== 1'b0) $display("FAIL tout_snap: snap0=%h irq=%b expected 0000/0", d, irq); else pass_cnt++;
        slave_acks = 1'b1;
        bank[1] = 16'h0002;
        push_scan();
        wait_scan("tout_next");
        read_snap(1, d);
        chk_cnt++; if (d !== 16'h0002 || irq !== 1'b1) $display("FAIL tout_recover: snap1=%h irq=%b expected 0002/1", d, irq); else pass_cnt++;
        enable = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic_scan();
        test_irq_collision();
        test_enable_drop();
        test_reset_mid_scan();
`ifdef ACK_TIMEOUT_EN
        test_timeout();
`endif
        tick(4);
        chk_cnt++; if (exp_q.size() != 0) $display("FAIL sb_final: %0d transactions outstanding expected 0", exp_q.size()); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/capreg_poller.md
Name: capreg_poller

Overview:
- Wishbone master that sequences a capture-register bank: reads every 16-bit word at a fixed period, then issues one clearing write.
- Stores the last scan in a snapshot buffer.
- Raises a sticky interrupt when any captured bit was set.
- Sits between the channel-FPGA capture register bank (slave) and the control/readout logic, so the host bus does not poll the bank directly.

Parameters:
- ADRBITS, 1, word-address width of the polled bank; NWORDS = 2**ADRBITS
- PERIOD, 1024, wb_clk cycles between scan starts (min 4*NWORDS+8)
- TOUT, 15, max wb_clk cycles waiting for m_ack before abort (only with ACK_TIMEOUT_EN)

Ports:
- wb_clk  in  1  clock
- wb_rst  in  1  synchronous active-high reset
- enable  in  1  1 = periodic scanning; 0 = finish current scan, then idle
- m_cyc  out  1  WB master cycle
- m_stb  out  1  WB master strobe
- m_we  out  1  WB master write enable
- m_adr  out  ADRBITS  WB master word address
- m_dat_o  out  16  WB master write data (always 0)
- m_dat_i  in  16  WB master read data
- m_ack  in  1  WB slave acknowledge
- snap_adr  in  ADRBITS  snapshot read address
- snap_dat  out  16  snapshot word, registered, 1-cycle latency
- irq  out  1  sticky: some scan saw a nonzero word
- irq_clr  in  1  single-cycle pulse, clears irq
- busy  out  1  scan in progress
- err  out  1  sticky timeout flag (ACK_TIMEOUT_EN only, else tied 0); cleared by irq_clr

Behaviour:
Reset values:
- All outputs 0; FSM in IDLE; period counter 0; snapshot words 0.

Period counter:
- Counts wb_clk cycles while enable=1; holds at 0 while enable=0.
- Reaching PERIOD-1 raises a start request and wraps to 0.
- A start request arriving while busy is dropped; scans never queue.

FSM states:
- IDLE: busy=0. On start request go to RD with m_adr=0.
- RD: drive m_cyc=m_stb=1, m_we=0. On m_ack, latch m_dat_i into a scan accumulator at word m_adr and go to RNEXT.
- RNEXT: deassert m_cyc/m_stb for 1 cycle. If m_adr=NWORDS-1 go to WR; else m_adr+1, back to RD.
- WR: m_cyc=m_stb=m_we=1, m_adr=0, m_dat_o=0. On m_ack go to DONE. The slave clears its whole bank on any write.
- DONE: deassert the bus. Copy the accumulator to the snapshot in one cycle (atomic for readers). If any accumulated word is nonzero, set irq. Return to IDLE.

Bus protocol and timing:
- Classic single-cycle WB handshake. m_stb is held until m_ack.
- The master never issues back-to-back strobes, because the slave acks one cycle after stb and acks every cycle stb is high.
- The snapshot is updated only in DONE. snap_dat is valid 1 cycle after snap_adr, even mid-scan, and shows the previous complete scan.
- Inherent loss window: bits set in the bank between the read of a word and the clear write are lost. The WR state directly follows the last read to keep this window at about 2*NWORDS+2 cycles. This is documented system behaviour, not a bug.

Interrupt and error flags:
- irq_clr in the same cycle as an irq set in DONE: set wins, irq stays 1.

Control corner cases:
- enable dropped mid-scan: the scan completes, including the clear, then the FSM idles.
- wb_rst mid-scan: m_cyc/m_stb drop in the same clock edge; the snapshot is cleared to 0; the accumulator is discarded.

Optional Feature:
- Macro: ACK_TIMEOUT_EN
- Defined: a counter runs while in RD or WR. If it reaches TOUT without m_ack, the FSM drops the bus, sets err, discards the accumulator (snapshot and irq unchanged), and goes to IDLE.
- Undefined: no counter; the FSM waits for m_ack indefinitely; err is constant 0.

Test Plan:
- Reset + idle: ADRBITS=1, enable=0 for 5000 cycles -> m_cyc never asserted; irq=0; snap_dat=0 for both addresses.
- Basic scan: enable=1, slave model returns 0x0000 and 0x8001 -> reads at adr 0 then 1, then one write adr 0 data 0. After DONE: snap[1]=0x8001, snap[0]=0, irq=1. Scan starts exactly PERIOD cycles apart.
- irq clear/set collision: pulse irq_clr in the DONE cycle of a scan with a nonzero word -> irq stays 1. Pulse irq_clr later with all-zero scans -> irq=0 and stays 0.
- enable drop mid-scan: deassert enable during the read of word 1 -> the write still occurs; no further m_cyc after DONE.
- Reset mid-scan: assert wb_rst while m_stb=1 in WR -> next cycle m_cyc=0, busy=0, snap=0, irq=0.
- Timeout (ACK_TIMEOUT_EN, TOUT=15): slave never acks word 0 -> m_cyc drops on the 15th cycle of RD, err=1, snapshot unchanged. The next period's scan proceeds normally once the slave acks.
